// File: rtl/dtw_pkg.sv
// ============================================================================
// Module   : dtw_pkg
// Brief    : Shared types and constants for the DTW query sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dtw_pkg;

    localparam int SAMPLE_W = 16;
    localparam int QPTR_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_SWEEP  = 3'd3,
        S_DRAIN  = 3'd4
    } qseq_state_t;

endpackage

`default_nettype wire

// File: rtl/dtw_qseq_outreg.sv
// ============================================================================
// Module   : dtw_qseq_outreg
// Brief    : Valid/ready pair register; q passes from memory on the fresh cycle, held afterwards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtw_qseq_outreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] ref_in,
    input  logic             first_in,
    input  logic             last_in,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] ref_out,
    output logic             first_out,
    output logic             last_out,
    output logic             slot_free
);

    localparam int PW = 2 * WIDTH + 2;

    // Layout: {q, ref, first, last}
    logic [PW-1:0] r_payload;
    logic          r_valid;
    logic          r_fresh;

    assign slot_free = !r_valid || ready;
    assign valid     = r_valid;
    // Memory data arrives the cycle after the read; once stalled, the captured copy is shown.
    assign q         = r_fresh ? q_in : r_payload[PW-1 -: WIDTH];
    assign ref_out   = r_payload[WIDTH+1 -: WIDTH];
    assign first_out = r_payload[1];
    assign last_out  = r_payload[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
            r_valid   <= 1'b0;
            r_fresh   <= 1'b0;
        end else begin
            r_fresh                  <= load;
            r_payload[PW-1 -: WIDTH] <= q;
            if (load) begin
                r_valid              <= 1'b1;
                r_payload[WIDTH+1:0] <= {ref_in, first_in, last_in};
            end else if (ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dtw_query_seq.sv
// ============================================================================
// Module   : dtw_query_seq
// Brief    : Loads the DTW query memory, then sweeps it once per reference sample.
//            Define DTW_QSEQ_BP_EN to add the out_ready backpressure port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtw_query_seq
    import dtw_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int PTR_W = QPTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_end,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [WIDTH-1:0] ref_data,
    output logic [PTR_W-1:0] mem_addr_r,
    output logic [PTR_W-1:0] mem_addr_w,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             out_valid,
`ifdef DTW_QSEQ_BP_EN
    input  logic             out_ready,
`endif
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_ref,
    output logic             out_first,
    output logic             out_last,
    output logic [PTR_W:0]   qlen,
    output logic             busy,
    output logic             err
);

    localparam int               DEPTH       = 2 ** PTR_W;
    localparam logic [PTR_W-1:0] c_last_addr = PTR_W'(DEPTH - 1);

    qseq_state_t      r_state;
    qseq_state_t      w_state_nxt;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_wcnt;
    logic [PTR_W:0]   r_qlen;
    logic [PTR_W:0]   w_wcnt_nxt;
    logic [WIDTH-1:0] r_ref;
    logic             r_err;

    logic w_out_ready;
    logic w_slot_free;
    logic w_start;
    logic w_wr;
    logic w_close;
    logic w_ref_acc;
    logic w_rd;
    logic w_rd_last;

`ifdef DTW_QSEQ_BP_EN
    assign w_out_ready = out_ready;
`else
    assign w_out_ready = 1'b1;
`endif

    assign w_start    = load_start && (r_state == S_IDLE || r_state == S_LOADED);
    assign w_wr       = (r_state == S_LOAD) && s_valid;
    assign w_wcnt_nxt = r_wcnt + (PTR_W + 1)'(w_wr);
    // Writing the top address closes the load even without load_end.
    assign w_close    = (r_state == S_LOAD) && (load_end || (w_wr && r_wptr == c_last_addr));
    assign w_ref_acc  = (r_state == S_LOADED) && !load_start && ref_valid;
    assign w_rd       = (r_state == S_SWEEP) && w_slot_free;
    assign w_rd_last  = ({1'b0, r_rptr} == (r_qlen - 1'b1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_close) w_state_nxt = (w_wcnt_nxt == '0) ? S_IDLE : S_LOADED;
            end
            S_LOADED: begin
                if (load_start)     w_state_nxt = S_LOAD;
                else if (ref_valid) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                if (w_rd && w_rd_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_slot_free) w_state_nxt = S_LOADED;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_wcnt  <= '0;
            r_qlen  <= '0;
            r_ref   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_wptr <= '0;
                r_wcnt <= '0;
                r_err  <= 1'b0;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
                r_wcnt <= w_wcnt_nxt;
            end
            // The previous query length stays valid until a reload actually closes.
            if (w_close) begin
                if (w_wcnt_nxt == '0) r_err  <= 1'b1;
                else                  r_qlen <= w_wcnt_nxt;
            end
            if (w_ref_acc) begin
                r_ref  <= ref_data;
                r_rptr <= '0;
            end
            if (w_rd && !w_rd_last) r_rptr <= r_rptr + 1'b1;
        end
    end

    assign s_ready    = (r_state == S_LOAD);
    assign ref_ready  = (r_state == S_LOADED) && !load_start;
    assign mem_wren   = w_wr;
    assign mem_addr_w = r_wptr;
    assign mem_din    = w_wr ? s_data : '0;
    assign mem_addr_r = (r_state == S_SWEEP) ? r_rptr : '0;
    assign qlen       = r_qlen;
    assign busy       = (r_state != S_IDLE) && (r_state != S_LOADED);
    assign err        = r_err;

    dtw_qseq_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_rd),
        .ready     (w_out_ready),
        .q_in      (mem_dout),
        .ref_in    (r_ref),
        .first_in  (r_rptr == '0),
        .last_in   (w_rd_last),
        .valid     (out_valid),
        .q         (out_q),
        .ref_out   (out_ref),
        .first_out (out_first),
        .last_out  (out_last),
        .slot_free (w_slot_free)
    );

endmodule

`default_nettype wire
